snake_grid_renderer: RTL and testbench

- Pipelined, parametrised pixel renderer for the snake playfield.
- Per scanline, fetches one grid row of multi-bit cell codes from the playfield RAM into a line buffer during horizontal blanking.
- Maps each active pixel's x_pos to a cell and emits registered 8-bit RGB from a 4-entry colour palette (empty/body/head/food), with a border colour outside the grid.
- Sits between the VGA timing generator and the DAC/HDMI encoder.

---
 rtl/snake_grid_renderer.sv | 176 +++++++++++++++++
 tb/tb_snake_grid_renderer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_grid_renderer.sv
// snake_grid_renderer: fetches one playfield row per line into a line
// buffer during blanking and renders palette RGB with a 2-clock latency.
// Ports: clk, rst (async active-low), frame_start, inrange, x_pos, y_pos,
//   ram_in -> ram_rd_en, read_address, de_out, red, green, blue.
// Option: define GRID_LINES_EN to draw border-coloured lines on empty cells.
module snake_grid_renderer #(
  parameter int          GRID_W     = 60,
  parameter int          GRID_H     = 60,
  parameter int          CELL_SHIFT = 3,
  parameter int          BPC        = 2,
  parameter int          ADDR_W     = 6,
  parameter int          RAM_LAT    = 1,
  parameter logic [23:0] COL_EMPTY  = 24'hFFFFFF,
  parameter logic [23:0] COL_BODY   = 24'h000000,
  parameter logic [23:0] COL_HEAD   = 24'h00A000,
  parameter logic [23:0] COL_FOOD   = 24'hFF0000,
  parameter logic [23:0] COL_BORDER = 24'h404040
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start,
  input  logic                  inrange,
  input  logic [9:0]            x_pos,
  input  logic [9:0]            y_pos,
  input  logic [GRID_W*BPC-1:0] ram_in,
  output logic                  ram_rd_en,
  output logic [ADDR_W-1:0]     read_address,
  output logic                  de_out,
  output logic [7:0]            red,
  output logic [7:0]            green,
  output logic [7:0]            blue
);

  localparam int CXW = 10 - CELL_SHIFT;
  localparam int CIW = $clog2(GRID_W);

  localparam logic [CXW-1:0] GW_C  = CXW'(GRID_W);
  localparam logic [10:0]    GH_R  = 11'(GRID_H);
  localparam logic [10:0]    AD_R  = 11'(2**ADDR_W);
  localparam logic [1:0]     LAT_M = 2'(RAM_LAT - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    LOAD
  } state_t;

  state_t state;
  logic [1:0] wcnt;
  logic tgt_ok;
  logic row_valid;
  logic [GRID_W-1:0][BPC-1:0] lbuf;

  logic [CXW-1:0] cell1;
  logic de1;
  logic ing1;

  logic fall;
  logic [10:0] yp1;
  logic [10:0] trow;
  logic [CXW-1:0] xcell;

  // de1 doubles as the registered inrange for edge detection
  assign fall  = de1 && !inrange;
  assign yp1   = {1'b0, y_pos} + 11'd1;
  assign trow  = yp1 >> CELL_SHIFT;
  assign xcell = x_pos[9:CELL_SHIFT];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      ram_rd_en    <= 1'b0;
      read_address <= '0;
      wcnt         <= '0;
      tgt_ok       <= 1'b0;
      row_valid    <= 1'b0;
      lbuf         <= '0;
    end else begin
      ram_rd_en <= 1'b0;
      unique case (state)
        IDLE: begin
          if (frame_start) begin
            state        <= REQ;
            ram_rd_en    <= 1'b1;
            read_address <= '0;
            tgt_ok       <= 1'b1;
          end else if (fall) begin
            state     <= REQ;
            ram_rd_en <= 1'b1;
            // rows past the RAM map to 0, never aliased
            read_address <= (trow < AD_R)
                          ? trow[ADDR_W-1:0] : '0;
            tgt_ok <= (trow < GH_R);
          end
        end
        REQ: begin
          state <= WAIT;
          wcnt  <= '0;
        end
        WAIT: begin
          if (wcnt == LAT_M) state <= LOAD;
          else wcnt <= wcnt + 2'd1;
        end
        LOAD: begin
          lbuf      <= ram_in;
          row_valid <= tgt_ok;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef GRID_LINES_EN
  logic gl1;
`else
  logic unused;
  assign unused = ^x_pos[CELL_SHIFT-1:0];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cell1 <= '0;
      de1   <= 1'b0;
      ing1  <= 1'b0;
`ifdef GRID_LINES_EN
      gl1   <= 1'b0;
`endif
    end else begin
      cell1 <= xcell;
      de1   <= inrange;
      ing1  <= (xcell < GW_C) && row_valid;
`ifdef GRID_LINES_EN
      gl1 <= (x_pos[CELL_SHIFT-1:0] == '0) ||
             (y_pos[CELL_SHIFT-1:0] == '0);
`endif
    end
  end

  logic [CIW-1:0] cidx;
  logic [BPC-1:0] code;
  logic [23:0]    pix;

  assign cidx = cell1[CIW-1:0];
  assign code = lbuf[cidx];

  always_comb begin
    pix = COL_BORDER;
    if (ing1) begin
      case (code)
        BPC'(0): pix = COL_EMPTY;
        BPC'(1): pix = COL_BODY;
        BPC'(2): pix = COL_HEAD;
        default: pix = COL_FOOD;
      endcase
`ifdef GRID_LINES_EN
      if (code == '0 && gl1) pix = COL_BORDER;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      de_out <= 1'b0;
      red    <= '0;
      green  <= '0;
      blue   <= '0;
    end else begin
      de_out <= de1;
      if (de1) {red, green, blue} <= pix;
      else     {red, green, blue} <= '0;
    end
  end

endmodule

// File: tb/tb_snake_grid_renderer.sv
// Directed bench for snake_grid_renderer: vector table plus
// hand sequences for fetch timing, arbitration, clamp and abort.
module tb_snake_grid_renderer;

  localparam logic [23:0] C_E = 24'hFFFFFF;
  localparam logic [23:0] C_B = 24'h000000;
  localparam logic [23:0] C_H = 24'h00A000;
  localparam logic [23:0] C_F = 24'hFF0000;
  localparam logic [23:0] C_X = 24'h404040;

  logic clk = 1'b0;
  logic rst;
  logic rst3;
  logic frame_start = 1'b0;
  logic inrange = 1'b0;
  logic [9:0] x_pos = '0;
  logic [9:0] y_pos = '0;

  logic [119:0] mem [64];
  logic [119:0] ram1 = '0;
  logic [119:0] d0 = '0;
  logic [119:0] d1 = '0;
  logic [119:0] d2 = '0;

  logic rd1, rd3;
  logic [5:0] ad1, ad3;
  logic de1o, de3o;
  logic [7:0] r1, g1, b1, r3, g3, b3;

  int checks = 0;
  int failures = 0;
  int cnt;

  always #5 clk = ~clk;

  snake_grid_renderer u_dut (
    .clk(clk), .rst(rst), .frame_start(frame_start),
    .inrange(inrange), .x_pos(x_pos), .y_pos(y_pos),
    .ram_in(ram1), .ram_rd_en(rd1), .read_address(ad1),
    .de_out(de1o), .red(r1), .green(g1), .blue(b1)
  );

  snake_grid_renderer #(.RAM_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst3), .frame_start(frame_start),
    .inrange(inrange), .x_pos(x_pos), .y_pos(y_pos),
    .ram_in(d2), .ram_rd_en(rd3), .read_address(ad3),
    .de_out(de3o), .red(r3), .green(g3), .blue(b3)
  );

  // latency-1 RAM for u_dut, latency-3 RAM for u_dut3
  always @(posedge clk) begin
    if (rd1) ram1 <= mem[ad1];
    if (rd3) d0 <= mem[ad3];
    d1 <= d0;
    d2 <= d1;
  end

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        inr;
    logic [23:0] rgb;
    logic        de;
  } vec_t;

  vec_t tv[39];

  function automatic logic [23:0] pal(input logic [1:0] c,
                                      input logic [9:0] x,
                                      input logic [9:0] y);
    logic [23:0] r;
    case (c)
      2'd0:    r = C_E;
      2'd1:    r = C_B;
      2'd2:    r = C_H;
      default: r = C_F;
    endcase
`ifdef GRID_LINES_EN
    if (c == 2'd0 && (x[2:0] == 3'd0 || y[2:0] == 3'd0)) r = C_X;
`endif
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic nclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic fall_at(input logic [9:0] y, input logic [5:0] ea,
                         input string nm);
    @(negedge clk); inrange = 1'b1; x_pos = '0; y_pos = y;
    @(negedge clk); inrange = 1'b0;
    @(negedge clk);
    chk({nm, "_rd"}, rd1, 1);
    chk({nm, "_addr"}, ad1, ea);
    @(negedge clk);
    chk({nm, "_rd_once"}, rd1, 0);
    nclk(6);
  endtask

  task automatic pix(input logic [9:0] x, input logic [9:0] y,
                     input logic [23:0] e, input string nm);
    @(negedge clk); inrange = 1'b1; x_pos = x; y_pos = y;
    @(negedge clk); inrange = 1'b0;
    @(negedge clk);
    chk(nm, {r1, g1, b1}, e);
    nclk(6);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[0] = 120'hE4;
    mem[1] = 120'h2;
    mem[2] = 120'h31;

    for (int i = 0; i < 32; i++)
      tv[i] = '{10'(i), 10'd1, 1'b1,
                pal(2'(i >> 3), 10'(i), 10'd1), 1'b1};
    tv[32] = '{10'd480, 10'd1, 1'b1, C_X, 1'b1};
    tv[33] = '{10'd639, 10'd2, 1'b1, C_X, 1'b1};
    tv[34] = '{10'd500, 10'd3, 1'b0, 24'h0, 1'b0};
    tv[35] = '{10'd8,   10'd4, 1'b1, C_B, 1'b1};
    tv[36] = '{10'd24,  10'd6, 1'b1, C_F, 1'b1};
    tv[37] = '{10'd16,  10'd5, 1'b1, C_H, 1'b1};
    tv[38] = '{10'd0,   10'd0, 1'b0, 24'h0, 1'b0};

    rst = 1'b1; rst3 = 1'b1;
    #2;
    rst = 1'b0; rst3 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rst_rgb", {r1, g1, b1}, 0);
      chk("rst_de", de1o, 0);
      chk("rst_rd", rd1, 0);
      frame_start = k[0];
      inrange = ~k[0];
      x_pos = 10'(k * 8);
      y_pos = 10'(k);
    end
    chk("rst_addr", ad1, 0);
    @(negedge clk);
    rst = 1'b1; rst3 = 1'b1;
    frame_start = 1'b0; inrange = 1'b0;
    nclk(2);

    // first fetch: buffer valid 3 clocks after the pulse
    @(negedge clk);
    frame_start = 1'b1; x_pos = 10'd8; y_pos = '0;
    @(negedge clk);
    frame_start = 1'b0;
    chk("fs_rd", rd1, 1);
    chk("fs_addr", ad1, 0);
    inrange = 1'b1;
    @(negedge clk);
    chk("fs_rd_once", rd1, 0);
    nclk(3);
    chk("load_early", {r1, g1, b1}, C_X);
    @(negedge clk);
    chk("load_done", {r1, g1, b1}, C_B);

    for (int i = 0; i < 41; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        chk($sformatf("vec%0d_rgb", i - 2), {r1, g1, b1}, tv[i-2].rgb);
        chk($sformatf("vec%0d_de", i - 2), de1o, tv[i-2].de);
      end
      if (i < 39) begin
        x_pos = tv[i].x; y_pos = tv[i].y; inrange = tv[i].inr;
      end else begin
        inrange = 1'b0;
      end
    end
    nclk(8);

    fall_at(10'd7, 6'd1, "fall_y7");
    pix(10'd0, 10'd8, C_H, "row1_head");
    fall_at(10'd8, 6'd1, "fall_y8");
    fall_at(10'd15, 6'd2, "fall_y15");
    pix(10'd0, 10'd17, C_B, "row2_body_edge");
    pix(10'd9, 10'd17, C_E, "row2_empty_in");
`ifdef GRID_LINES_EN
    pix(10'd8, 10'd17, C_X, "gl_empty_xline");
    pix(10'd9, 10'd16, C_X, "gl_empty_yline");
`else
    pix(10'd8, 10'd17, C_E, "nogl_empty_x8");
    pix(10'd9, 10'd16, C_E, "nogl_empty_y16");
`endif

    // frame_start beats a simultaneous falling edge
    @(negedge clk); inrange = 1'b1; x_pos = '0; y_pos = 10'd15;
    @(negedge clk); inrange = 1'b0; frame_start = 1'b1;
    @(negedge clk); frame_start = 1'b0;
    chk("collide_rd", rd1, 1);
    chk("collide_addr", ad1, 0);
    nclk(6);
    pix(10'd8, 10'd3, C_B, "collide_row0");

    fall_at(10'd479, 6'd60, "bottom");
    pix(10'd0, 10'd480, C_X, "below_grid_x0");
    pix(10'd200, 10'd480, C_X, "below_grid_x200");
    fall_at(10'd527, 6'd0, "clamp");
    pix(10'd16, 10'd530, C_X, "clamp_invalid");

    // RAM_LAT=3: a trigger during WAIT is dropped
    nclk(4);
    cnt = 0;
    @(negedge clk); frame_start = 1'b1; inrange = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      frame_start = (k == 2);
      if (rd3) cnt++;
    end
    chk("lat3_single_rd", cnt, 1);
    nclk(2);

    // reset during WAIT aborts the fetch
    @(negedge clk); frame_start = 1'b1;
    @(negedge clk); frame_start = 1'b0;
    @(negedge clk);
    rst3 = 1'b0;
    #1;
    chk("abort_rd_low", rd3, 0);
    chk("abort_addr", ad3, 0);
    @(negedge clk); rst3 = 1'b1;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (rd3) cnt++;
    end
    chk("abort_no_refetch", cnt, 0);

    @(negedge clk); inrange = 1'b1; x_pos = 10'd8; y_pos = '0;
    @(negedge clk); inrange = 1'b0;
    @(negedge clk);
    chk("abort_buf_clear", {r3, g3, b3}, C_X);
    chk("abort_fsm_idle", rd3, 1);
    inrange = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 6) chk("lat3_early", {r3, g3, b3}, C_X);
      if (k == 7) chk("lat3_load", {r3, g3, b3}, C_B);
    end
    @(negedge clk); inrange = 1'b0;
    nclk(8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
